mult_rr_scheduler: RTL and testbench

- Shares one signed N-bit start/done sequential multiplier (`mult_with_no_sm`-style interface) among M requesters.
- Arbitration is round-robin.
- The block latches the granted operands, pulses start and waits for the multiplier's done/release handshake. It then returns the 2N-bit product to the granted requester.
- It sits between client datapaths and the single multiplier instance.

---
 rtl/mult_rr_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_mult_rr_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mult_rr_scheduler
//   Shares one signed N-bit start/done sequential multiplier among M
//   requesters using round-robin arbitration. In IDLE it grants one requester
//   and latches that requester's operands. It then pulses mul_start and waits
//   for the multiplier's done level to rise (product captured) and fall again
//   (multiplier released). Finally it pulses the granted requester's
//   res_valid bit for one cycle with the 2N-bit product on res_y.
//
//   Optional feature, enabled by defining MULT_RR_TIMEOUT_EN:
//     A cycle counter runs while waiting on the multiplier. After TIMEOUT
//     cycles the operation is aborted and answered with res_err=1, res_y=0.
//     With the macro undefined, res_err is tied low and the block waits
//     indefinitely.
//
// Ports
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   req[M]         : per-requester request level, held until own res_valid
//   op_a, op_b     : flattened signed operands, slice i = op[i*N +: N]
//   res_valid[M]   : one-hot single-cycle result strobe
//   res_y[2N]      : product of the last completed operation (held)
//   res_err        : abort flag, qualified by res_valid
//   busy           : high in every state except IDLE
//   mul_start      : single-cycle start pulse to the multiplier
//   mul_a, mul_b   : registered operands to the multiplier
//   mul_y, mul_done: multiplier product and done level
// -----------------------------------------------------------------------------
module mult_rr_scheduler #(
  parameter int unsigned N       = 8,
  parameter int unsigned M       = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [M-1:0]     req,
  input  logic [M*N-1:0]   op_a,
  input  logic [M*N-1:0]   op_b,
  output logic [M-1:0]     res_valid,
  output logic [2*N-1:0]   res_y,
  output logic             res_err,
  output logic             busy,
  output logic             mul_start,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  input  logic [2*N-1:0]   mul_y,
  input  logic             mul_done
);

  localparam int unsigned PW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    WAIT_REL,
    RESP
  } state_e;

  state_e         state_q, state_d;
  // ptr_q is both the round-robin pointer and the current grant index:
  // every grant sets the pointer to the granted requester.
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]   mul_a_q, mul_a_d;
  logic [N-1:0]   mul_b_q, mul_b_d;
  logic [2*N-1:0] res_y_q, res_y_d;

  logic [N-1:0]   op_a_arr [M];
  logic [N-1:0]   op_b_arr [M];

  logic           found;
  logic [PW-1:0]  pick;
  logic [PW-1:0]  scan_idx;
  logic           abort;

  for (genvar i = 0; i < M; i++) begin : g_unpack
    assign op_a_arr[i] = op_a[i*N +: N];
    assign op_b_arr[i] = op_b[i*N +: N];
  end

  // Round-robin pick: first set request scanning from ptr+1 upward with wrap.
  // Offset M revisits ptr itself, so it has the lowest priority.
  always_comb begin
    found    = 1'b0;
    pick     = ptr_q;
    scan_idx = '0;
    for (int unsigned k = 1; k <= M; k++) begin
      scan_idx = PW'((32'(ptr_q) + k) % M);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

`ifdef MULT_RR_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          timed_out;

  // The counter spans WAIT_DONE and WAIT_REL together and saturates at the
  // limit, so a done edge landing on the limit still aborts in WAIT_REL if
  // the multiplier never releases.
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));
  assign abort     = timed_out &&
                     (((state_q == WAIT_DONE) && !mul_done) ||
                      ((state_q == WAIT_REL)  &&  mul_done));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case (state_q)
      ISSUE: begin
        cnt_d = '0;
        err_d = 1'b0;
      end
      WAIT_DONE, WAIT_REL: begin
        if (abort) begin
          err_d = 1'b1;
        end else if (!timed_out) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign res_err = err_q && (state_q == RESP);
`else
  assign abort   = 1'b0;
  assign res_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    res_y_d = res_y_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          ptr_d   = pick;
          mul_a_d = op_a_arr[pick];
          mul_b_d = op_b_arr[pick];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mul_done) begin
          res_y_d = mul_y;
          state_d = WAIT_REL;
        end else if (abort) begin
          res_y_d = '0;
          state_d = RESP;
        end
      end
      WAIT_REL: begin
        if (!mul_done) begin
          state_d = RESP;
        end else if (abort) begin
          res_y_d = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PW'(M - 1);
      mul_a_q <= '0;
      mul_b_q <= '0;
      res_y_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      res_y_q <= res_y_d;
    end
  end

  always_comb begin
    res_valid = '0;
    if (state_q == RESP) begin
      res_valid[ptr_q] = 1'b1;
    end
  end

  assign res_y     = res_y_q;
  assign busy      = (state_q != IDLE);
  assign mul_start = (state_q == ISSUE);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
module tb_mult_rr_scheduler;

  localparam int N  = 8;
  localparam int M  = 4;
  localparam int TO = 16;
  localparam int W  = 2 * N;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [M-1:0]   req;
  logic [M*N-1:0] op_a, op_b;
  logic [M-1:0]   res_valid;
  logic [W-1:0]   res_y;
  logic           res_err, busy, mul_start;
  logic [N-1:0]   mul_a, mul_b;
  logic [W-1:0]   mul_y;
  logic           mul_done;

  mult_rr_scheduler #(.N(N), .M(M), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_y(res_y), .res_err(res_err), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_y(mul_y), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] sw(input int v);
    return W'(v);
  endfunction

  // ---------------- behavioural multiplier (start/done/release) -------------
  int          m_lat_fix = 3, m_hold_fix = 2;
  bit          m_hang = 0;
  int          m_cnt, m_hold;
  bit          m_busy = 0;
  logic [W-1:0] m_y;

  initial begin
    mul_done = 1'b0;
    mul_y    = '0;
    forever begin
      @(negedge clk);
      if (mul_start && !m_hang) begin
        m_y      = $signed(mul_a) * $signed(mul_b);
        m_cnt    = (m_lat_fix > 0) ? m_lat_fix : int'($urandom_range(1, 6));
        m_hold   = (m_hold_fix > 0) ? m_hold_fix : int'($urandom_range(1, 3));
        m_busy   = 1;
        mul_done = 1'b0;
      end else if (m_busy) begin
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            mul_done = 1'b1;
            mul_y    = m_y;
          end
        end else begin
          m_hold--;
          if (m_hold == 0) begin
            mul_done = 1'b0;
            m_busy   = 0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard + monitor ------------------------------------
  typedef struct {
    int          idx;
    logic [W-1:0] y;
    bit          err;
    int          t_issue;
  } exp_t;

  exp_t         sb[$];
  logic [M-1:0] resp_vec[$];
  logic [W-1:0] resp_yq[$];
  logic [M-1:0] done_flag = '0;
  int           model_ptr = M - 1;
  int           starts = 0;
  int           cyc = 0;
  logic [M-1:0]   prev_req = '0;
  logic [M*N-1:0] prev_opa = '0, prev_opb = '0;

  initial begin
    exp_t e;
    int g;
    logic signed [N-1:0] ea, eb;
    forever begin
      @(negedge clk);
      cyc++;
      if (mul_start) begin
        // The grant was made at the previous edge from the request vector
        // visible during the previous cycle.
        g = -1;
        for (int k = 1; k <= M; k++) begin
          int j;
          j = (model_ptr + k) % M;
          if (g < 0 && prev_req[j]) g = j;
        end
        if (g < 0) begin
          check("spurious_start", {prev_req, mul_start}, {{M{1'b0}}, 1'b0});
        end else begin
          check("one_outstanding", sb.size(), 0);
          model_ptr = g;
          ea = prev_opa[g*N +: N];
          eb = prev_opb[g*N +: N];
          check("mul_operands", {mul_a, mul_b}, {ea, eb});
          e.idx = g;
`ifdef MULT_RR_TIMEOUT_EN
          e.err = m_hang;
`else
          e.err = 0;
`endif
          e.y       = e.err ? '0 : W'(ea * eb);
          e.t_issue = cyc;
          sb.push_back(e);
          starts++;
        end
      end
      if (res_valid != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_res_valid", res_valid, '0);
        end else begin
          e = sb.pop_front();
          check("res_valid_onehot", res_valid, M'(1) << e.idx);
          check("res_y", res_y, e.y);
          check("res_err", res_err, e.err);
          if (e.err) check("timeout_latency", cyc - e.t_issue, TO + 1);
        end
        resp_vec.push_back(res_valid);
        resp_yq.push_back(res_y);
        done_flag = done_flag | res_valid;
      end
      prev_req = req;
      prev_opa = op_a;
      prev_opb = op_b;
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    op_a[i*N +: N] = a;
    op_b[i*N +: N] = b;
  endtask

  task automatic wait_flags(input logic [M-1:0] mask, input int budget, input string nm);
    for (int t = 0; t < budget; t++) begin
      tick();
      for (int i = 0; i < M; i++) if (mask[i] && done_flag[i]) req[i] = 1'b0;
      if ((done_flag & mask) == mask) break;
    end
    check(nm, done_flag & mask, mask);
    done_flag = done_flag & ~mask;
  endtask

  task automatic wait_start(input int budget, input string nm);
    for (int t = 0; t < budget && !mul_start; t++) tick();
    check(nm, mul_start, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    for (int t = 0; t < budget && (busy || sb.size() != 0); t++) tick();
    check(nm, {busy, 1'b0}, {1'b0, 1'b0});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    sb.delete();
    model_ptr = M - 1;
    repeat (2) tick();
    rst_n = 1'b1;
    done_flag = '0;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    summary();
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence -------------------------------------------
  initial begin
    int s0;
    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) tick();
    check("reset_res", {res_valid, res_y, res_err}, '0);
    check("reset_ctl", {busy, mul_start, mul_a, mul_b}, '0);
    rst_n = 1'b1;
    tick();

    // T1: single requester 0, 9*9
    resp_vec.delete(); resp_yq.delete(); s0 = starts;
    set_op(0, 8'sd9, 8'sd9);
    req[0] = 1'b1;
    wait_flags(4'b0001, 40, "t1_served");
    wait_idle(20, "t1_idle");
    check("t1_starts", starts - s0, 1);
    check("t1_vec", resp_vec[0], 4'b0001);
    check("t1_y", resp_yq[0], sw(81));
    tick();
    check("t1_busy_low", busy, 1'b0);

    // T2: requesters 1 and 3 together, ptr = 0
    resp_vec.delete(); resp_yq.delete(); s0 = starts;
    set_op(1, -8'sd7, 8'sd6);
    set_op(3, 8'sd10, -8'sd3);
    req = 4'b1010;
    wait_flags(4'b1010, 80, "t2_served");
    wait_idle(20, "t2_idle");
    check("t2_starts", starts - s0, 2);
    check("t2_order", {resp_vec[0], resp_vec[1]}, {4'b0010, 4'b1000});
    check("t2_y", {resp_yq[0], resp_yq[1]}, {sw(-42), sw(-30)});

    // T3: all four held continuously
    resp_vec.delete(); resp_yq.delete();
    set_op(0, -8'sd5, -8'sd5);
    set_op(1, 8'sd0, 8'sd15);
    set_op(2, 8'sd9, 8'sd9);
    set_op(3, -8'sd7, 8'sd6);
    req = 4'b1111;
    for (int t = 0; t < 200 && resp_vec.size() < 8; t++) tick();
    req = '0;
    check("t3_count", resp_vec.size(), 8);
    for (int k = 0; k < 8 && k < resp_vec.size(); k++) begin
      logic [W-1:0] tab [4];
      tab[0] = sw(25); tab[1] = sw(0); tab[2] = sw(81); tab[3] = sw(-42);
      check($sformatf("t3_grant%0d", k), resp_vec[k], M'(1) << (k % M));
      check($sformatf("t3_y%0d", k), resp_yq[k], tab[k % M]);
    end
    wait_idle(20, "t3_idle");
    done_flag = '0;

    // T4: requester 2 drops req one cycle after ISSUE
    resp_vec.delete(); resp_yq.delete();
    set_op(2, 8'sd10, -8'sd3);
    req[2] = 1'b1;
    wait_start(10, "t4_start");
    tick();
    req[2] = 1'b0;
    wait_flags(4'b0100, 40, "t4_still_served");
    check("t4_y", resp_yq[0], sw(-30));
    set_op(0, 8'sd3, -8'sd4);
    req[0] = 1'b1;
    wait_flags(4'b0001, 40, "t4_next");
    check("t4_next_vec", resp_vec[1], 4'b0001);
    check("t4_next_y", resp_yq[1], sw(-12));
    wait_idle(20, "t4_idle");

    // T5: reset during WAIT_DONE
    m_lat_fix = 8;
    resp_vec.delete(); resp_yq.delete();
    set_op(1, 8'sd5, 8'sd5);
    req[1] = 1'b1;
    wait_start(10, "t5_start");
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_async_res", {res_valid, res_y, res_err}, '0);
    check("t5_async_ctl", {busy, mul_start, mul_a, mul_b}, '0);
    req = '0;
    sb.delete();
    model_ptr = M - 1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (15) tick();
    check("t5_no_late_resp", resp_vec.size(), 0);
    check("t5_idle", busy, 1'b0);
    done_flag = '0;
    m_lat_fix = 3;
    set_op(0, 8'sd2, 8'sd3);
    set_op(3, 8'sd4, 8'sd4);
    req = 4'b1001;
    wait_flags(4'b1001, 80, "t5_served");
    check("t5_order", {resp_vec[0], resp_vec[1]}, {4'b0001, 4'b1000});
    check("t5_y", {resp_yq[0], resp_yq[1]}, {sw(6), sw(16)});
    wait_idle(20, "t5_idle2");

    // T6: multiplier never answers
    resp_vec.delete(); resp_yq.delete();
    m_hang = 1;
    set_op(2, 8'sd7, 8'sd7);
    req[2] = 1'b1;
`ifdef MULT_RR_TIMEOUT_EN
    wait_flags(4'b0100, 40, "t6_timeout_resp");
    check("t6_y_zero", resp_yq[0], '0);
    m_hang = 0;
    wait_idle(20, "t6_idle");
`else
    repeat (100) tick();
    check("t6_busy_hangs", busy, 1'b1);
    check("t6_no_resp", resp_vec.size(), 0);
    m_hang = 0;
    do_reset();
    tick();
    check("t6_recovered", busy, 1'b0);
`endif

    // Random traffic: random operands, latencies, arrivals and abandonment
    m_lat_fix  = 0;
    m_hold_fix = 0;
    s0 = starts;
    for (int c = 0; c < 2500; c++) begin
      tick();
      for (int i = 0; i < M; i++) begin
        if (done_flag[i]) begin
          req[i] = 1'b0;
          done_flag[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_op(i, N'($urandom), N'($urandom));
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 99) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    wait_idle(100, "rand_drain");
    check("rand_sb_empty", sb.size(), 0);
    check("rand_progress", (starts - s0) > 50, 1'b1);

    summary();
    $finish;
  end

endmodule
